// File: rtl/apb_slave_mem_pkg.sv
// Shared definitions for the APB4 scratch memory completer.
//   state_e      : FSM encoding (IDLE / WAIT / ACCESS, 2 bits)
//   strb_width   : APB4 strobe width for a given data width
//   off_width    : byte-offset bits inside one data word
//   idx_width    : bits needed to index DEPTH words (at least 1)
//   WcntW        : width of the wait-state counter (WAIT_STATES <= 15)
package apb_slave_mem_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StAccess = 2'd2
    } state_e;

    localparam int unsigned WcntW = 4;

    function automatic int unsigned strb_width(int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned off_width(int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int unsigned idx_width(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_slave_mem_regfile.sv
// DEPTH x DATA_W word array with synchronous clear, byte-enable write port and
// combinational read port.
//   clk_i    : clock, rising edge
//   clr_i    : synchronous clear of every word (wins over a write)
//   we_i     : write enable
//   widx_i   : write word index
//   wdata_i  : write data
//   wstrb_i  : write byte lanes
//   ridx_i   : read word index
//   rdata_o  : read data (combinational)
module apb_slave_mem_regfile
    import apb_slave_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned IdxW   = idx_width(DEPTH),
    parameter int unsigned StrbW  = strb_width(DATA_W)
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [IdxW-1:0]   widx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [StrbW-1:0]  wstrb_i,
    input  logic [IdxW-1:0]   ridx_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < int'(StrbW); b++) begin
                if (wstrb_i[b]) begin
                    mem_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer in front of a byte-writable word memory, with configurable
// wait states, PSTRB byte lanes and PSLVERR on out-of-range / misaligned access.
//   pclk_i    : bus clock, rising edge
//   prst_ni   : synchronous active-low reset
//   paddr_i   : byte address
//   psel_i    : completer select
//   penable_i : access phase
//   pwrite_i  : 1 = write, 0 = read
//   pwdata_i  : write data
//   pstrb_i   : write byte lanes (ignored on reads)
//   pready_o  : transfer completes this cycle
//   pslverr_o : error response, only while pready_o = 1
//   prdata_o  : read data, valid while pready_o = 1 on a read
module apb_slave_mem
    import apb_slave_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                        pclk_i,
    input  logic                        prst_ni,
    input  logic [ADDR_W-1:0]           paddr_i,
    input  logic                        psel_i,
    input  logic                        penable_i,
    input  logic                        pwrite_i,
    input  logic [DATA_W-1:0]           pwdata_i,
    input  logic [strb_width(DATA_W)-1:0] pstrb_i,
    output logic                        pready_o,
    output logic                        pslverr_o,
    output logic [DATA_W-1:0]           prdata_o
);

    localparam int unsigned StrbW    = strb_width(DATA_W);
    localparam int unsigned OffW     = off_width(DATA_W);
    localparam int unsigned MemIdxW  = idx_width(DEPTH);
    localparam int unsigned AddrIdxW = ADDR_W - OffW;
    localparam logic [WcntW-1:0] WaitInit =
        WcntW'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    state_e               state_q, state_d;
    logic [WcntW-1:0]     wcnt_q, wcnt_d;
    logic [MemIdxW-1:0]   idx_q;
    logic                 pwrite_q;
    logic                 err_q;
    logic [DATA_W-1:0]    prdata_q;

    logic                 setup;
    logic                 access;
    logic [AddrIdxW-1:0]  addr_idx;
    logic                 misaligned;
    logic                 out_of_range;
    logic                 err_in;
    logic [MemIdxW-1:0]   rd_idx;
    logic                 rd_err;
    logic                 rd_write;
    logic                 enter_access;
    logic                 mem_we;
    logic [DATA_W-1:0]    mem_rdata;

    assign setup  = psel_i & ~penable_i;
    assign access = psel_i & penable_i;

    // Address / error decode of the live bus address (used at the setup edge).
    assign addr_idx     = paddr_i[ADDR_W-1:OffW];
    assign misaligned   = |paddr_i[OffW-1:0];
    assign out_of_range = 32'(addr_idx) >= DEPTH;
    assign err_in       = misaligned | out_of_range;

    // With zero wait states ACCESS is entered straight from the setup edge, so
    // the read must use the live address rather than the not-yet-written latch.
    assign rd_idx   = (state_q == StIdle) ? addr_idx[MemIdxW-1:0] : idx_q;
    assign rd_err   = (state_q == StIdle) ? err_in : err_q;
    assign rd_write = (state_q == StIdle) ? pwrite_i : pwrite_q;

    assign enter_access = (state_d == StAccess) && (state_q != StAccess);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            StIdle: begin
                // psel & penable here is a protocol violation and is ignored.
                if (setup) begin
                    if (WAIT_STATES == 0) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StWait;
                        wcnt_d  = WaitInit;
                    end
                end
            end
            StWait: begin
                if (!access) begin
                    state_d = StIdle;
                end else if (wcnt_q == '0) begin
                    state_d = StAccess;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            StAccess: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (!prst_ni) begin
            state_q  <= StIdle;
            wcnt_q   <= '0;
            idx_q    <= '0;
            pwrite_q <= 1'b0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if ((state_q == StIdle) && setup) begin
                idx_q    <= addr_idx[MemIdxW-1:0];
                pwrite_q <= pwrite_i;
                err_q    <= err_in;
            end
            if (enter_access && !rd_write) begin
                prdata_q <= rd_err ? '0 : mem_rdata;
            end
        end
    end

    assign mem_we = (state_q == StAccess) & access & pwrite_q & ~err_q;

    apb_slave_mem_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IdxW   (MemIdxW),
        .StrbW  (StrbW)
    ) u_regfile (
        .clk_i   (pclk_i),
        .clr_i   (~prst_ni),
        .we_i    (mem_we),
        .widx_i  (idx_q),
        .wdata_i (pwdata_i),
        .wstrb_i (pstrb_i),
        .ridx_i  (rd_idx),
        .rdata_o (mem_rdata)
    );

    assign pready_o  = (state_q == StAccess);
    assign pslverr_o = pready_o & err_q;
    assign prdata_o  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: one instance with no wait states, one with three.
// Both share the bus except for their select lines.
module tb_apb_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  paddr;
    logic        psel0, psel1, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        rdy0, rdy1, err0, err1;
    logic [31:0] rd0, rd1;

    int total = 0;
    int bad   = 0;

    // Reference model: memory contents and last read value per instance.
    logic [31:0] model_mem [2][32];
    logic [31:0] model_rd  [2];

    always #5 clk = ~clk;

    apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(32), .WAIT_STATES(0)) u_dut0 (
        .pclk_i    (clk),
        .prst_ni   (rst_n),
        .paddr_i   (paddr),
        .psel_i    (psel0),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .pwdata_i  (pwdata),
        .pstrb_i   (pstrb),
        .pready_o  (rdy0),
        .pslverr_o (err0),
        .prdata_o  (rd0)
    );

    apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(32), .WAIT_STATES(3)) u_dut1 (
        .pclk_i    (clk),
        .prst_ni   (rst_n),
        .paddr_i   (paddr),
        .psel_i    (psel1),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .pwdata_i  (pwdata),
        .pstrb_i   (pstrb),
        .pready_o  (rdy1),
        .pslverr_o (err1),
        .prdata_o  (rd1)
    );

    function automatic logic get_rdy(input int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? err0 : err1;
    endfunction

    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? rd0 : rd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic set_psel(input int d, input logic v);
        if (d == 0) psel0 = v;
        else        psel1 = v;
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            model_rd[d] = '0;
            for (int i = 0; i < 32; i++) model_mem[d][i] = '0;
        end
    endtask

    // Complete transfer; called just after a rising edge, returns just after one.
    task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st, input string tag);
        int  cyc;
        bit  done;
        bit  e;
        int  idx;
        int  w;
        w   = (d == 0) ? 0 : 3;
        idx = int'(a) / 4;
        e   = ((int'(a) % 4) != 0) || (idx >= 32);
        set_psel(d, 1'b1);
        penable = 1'b0;
        paddr   = a;
        pwrite  = wr;
        pwdata  = wd;
        pstrb   = st;
        @(posedge clk) #1;
        penable = 1'b1;
        cyc  = 1;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (get_rdy(d)) done = 1'b1;
            else begin
                check({tag, "_err_while_wait"}, 32'(get_err(d)), 32'd0);
                @(posedge clk) #1;
            end
        end
        if (!done) begin
            check({tag, "_timeout"}, 32'(get_rdy(d)), 32'd1);
        end else begin
            check({tag, "_latency"}, 32'(cyc), 32'(2 + w));
            check({tag, "_pslverr"}, 32'(get_err(d)), 32'(e));
            if (!e && wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (st[b]) model_mem[d][idx][b*8 +: 8] = wd[b*8 +: 8];
                end
            end
            if (!wr) model_rd[d] = e ? 32'd0 : model_mem[d][idx];
            check({tag, "_prdata"}, get_rd(d), model_rd[d]);
        end
        @(posedge clk) #1;
        set_psel(d, 1'b0);
        penable = 1'b0;
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] wd;
        logic        wr;
        int          d;

        rst_n = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pready0", 32'(rdy0), 32'd0);
        check("rst_pready1", 32'(rdy1), 32'd0);
        check("rst_pslverr0", 32'(err0), 32'd0);
        check("rst_prdata0", rd0, 32'd0);
        check("rst_prdata1", rd1, 32'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk) #1;

        // Basic write/read with no wait states.
        xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, "t1_wr");
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, "t1_rd");

        // Byte strobes.
        xfer(0, 1'b1, 8'h08, 32'hFFFFFFFF, 4'hF, "t2_wr_ff");
        xfer(0, 1'b1, 8'h08, 32'h00000000, 4'b0101, "t2_wr_strb");
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, "t2_rd");
        check("t2_value", rd0, 32'hFF00FF00);

        // Out-of-range read and misaligned write.
        xfer(0, 1'b0, 8'h80, 32'h0, 4'h0, "t3_rd_oor");
        xfer(0, 1'b1, 8'h05, 32'h12345678, 4'hF, "t3_wr_mis");
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, "t3_rd_word1");
        xfer(0, 1'b1, 8'h08, 32'h0BADF00D, 4'h0, "t3_wr_nostrb");
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, "t3_rd_nostrb");

        // Three wait states, back-to-back write then read.
        xfer(1, 1'b1, 8'h0C, 32'hCAFEF00D, 4'hF, "t4_wr");
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, "t4_rd");

        // Abort during WAIT.
        psel1 = 1'b1; penable = 1'b0; paddr = 8'h0C; pwrite = 1'b1;
        pwdata = 32'h55555555; pstrb = 4'hF;
        @(posedge clk) #1;
        penable = 1'b1;
        @(negedge clk);
        check("t5_wait_pready", 32'(rdy1), 32'd0);
        @(posedge clk) #1;
        psel1 = 1'b0; penable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_idle_pready", 32'(rdy1), 32'd0);
        end
        @(posedge clk) #1;
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, "t5_rd");

        // Random traffic against the model.
        for (int i = 0; i < 80; i++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(0, 31) * 4);
            else                           a = 8'($urandom_range(0, 255));
            wd = $urandom;
            xfer(d, wr, a, wd, 4'($urandom_range(0, 15)), "rnd");
        end

        // Reset in the middle of a waited write.
        psel1 = 1'b1; penable = 1'b0; paddr = 8'h10; pwrite = 1'b1;
        pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
        @(posedge clk) #1;
        penable = 1'b1;
        @(posedge clk) #1;
        rst_n = 1'b0;
        @(posedge clk) #1;
        psel1 = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("t6_pready1", 32'(rdy1), 32'd0);
        check("t6_pslverr1", 32'(err1), 32'd0);
        check("t6_prdata1", rd1, 32'd0);
        check("t6_prdata0", rd0, 32'd0);
        model_clear();
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk) #1;
        for (int i = 0; i < 32; i++) begin
            xfer(1, 1'b0, 8'(i * 4), 32'h0, 4'h0, "t6_clear1");
        end
        for (int i = 0; i < 32; i += 5) begin
            xfer(0, 1'b0, 8'(i * 4), 32'h0, 4'h0, "t6_clear0");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
